// File: rtl/wave_gen.sv
// wave_gen: square/saw/triangle sample generator stepped by rising edges of a synchronised divided clock.
// Latency: sample_valid rises 4 ref_clock edges after the edge at which s1 first captures wave_clock high.
// Backpressure: none; enable low stops new steps while samples already in the pipeline still complete.
// Optional feature: define WAVE_GEN_DUTY_CTRL_EN to add a programmable square-wave duty input.
module wave_gen #(
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 8
) (
    input  logic               ref_clock,
    input  logic               rst_n,
    input  logic               wave_clock,
    input  logic               enable,
    input  logic               phase_clr,
    input  logic [1:0]         wave_sel,
    input  logic [DATA_W-1:0]  amplitude,
`ifdef WAVE_GEN_DUTY_CTRL_EN
    input  logic [PHASE_W-1:0] duty,
`endif
    output logic [DATA_W-1:0]  sample,
    output logic               sample_valid,
    output logic               period_done
);

    localparam int PROD_W = 2 * DATA_W + 1;

    typedef enum logic [1:0] {
        SEL_SQUARE = 2'b00,
        SEL_SAW    = 2'b01,
        SEL_TRI    = 2'b10,
        SEL_ZERO   = 2'b11
    } wave_sel_e;

    // synchroniser and edge detect
    logic [2:0]         sync_q;
    logic               step;

    // phase stage
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               upd_q, upd_d;
    logic               wrap_q, wrap_d;

    // waveform shaping
    logic               sq_high;
    logic [PHASE_W-2:0] tri_fold;
    logic [DATA_W-1:0]  saw_raw;
    logic [DATA_W-1:0]  tri_raw;
    logic [DATA_W-1:0]  raw_d;

    // stage 1
    logic [DATA_W-1:0]  st1_raw_q;
    logic [DATA_W-1:0]  st1_amp_q;
    logic               st1_vld_q;
    logic               st1_wrap_q;

    // stage 2
    logic [DATA_W:0]    amp_p1;
    logic [PROD_W-1:0]  prod;
    logic [DATA_W-1:0]  sample_d;
    logic [DATA_W-1:0]  sample_q;
    logic               sample_valid_q;
    logic               period_done_q;

    // Three-flop synchroniser; wave_clock is treated as asynchronous data.
    always_ff @(posedge ref_clock or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], wave_clock};
        end
    end

    // One step per synchronised rising edge, gated by enable.
    assign step = sync_q[1] & ~sync_q[2] & enable;

    // Phase next-state: clear beats step and never flags a wrap.
    always_comb begin
        phase_d = phase_q;
        upd_d   = 1'b0;
        wrap_d  = 1'b0;
        if (phase_clr) begin
            phase_d = '0;
        end else if (step) begin
            phase_d = phase_q + PHASE_W'(1);
            upd_d   = 1'b1;
            wrap_d  = &phase_q;
        end
    end

    // Phase register plus the "new phase" and wrap markers for the next stage.
    always_ff @(posedge ref_clock or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            upd_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            upd_q   <= upd_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef WAVE_GEN_DUTY_CTRL_EN
    assign sq_high = (phase_q < duty);
`else
    assign sq_high = ~phase_q[PHASE_W-1];
`endif

    // Triangle folds the lower bits around the half-period point.
    assign tri_fold = phase_q[PHASE_W-1] ? ~phase_q[PHASE_W-2:0] : phase_q[PHASE_W-2:0];

    // Resize phase and folded phase to the sample width, keeping the MSBs aligned.
    generate
        if (PHASE_W >= DATA_W) begin : g_saw_trunc
            assign saw_raw = phase_q[PHASE_W-1 -: DATA_W];
        end else begin : g_saw_pad
            assign saw_raw = {phase_q, {(DATA_W - PHASE_W){1'b0}}};
        end
        if (PHASE_W - 1 >= DATA_W) begin : g_tri_trunc
            assign tri_raw = tri_fold[PHASE_W-2 -: DATA_W];
        end else begin : g_tri_pad
            assign tri_raw = {tri_fold, {(DATA_W - PHASE_W + 1){1'b0}}};
        end
    endgenerate

    // Select the unscaled sample for the current phase.
    always_comb begin
        raw_d = '0;
        case (wave_sel_e'(wave_sel))
            SEL_SQUARE: raw_d = sq_high ? {DATA_W{1'b1}} : '0;
            SEL_SAW:    raw_d = saw_raw;
            SEL_TRI:    raw_d = tri_raw;
            SEL_ZERO:   raw_d = '0;
            default:    raw_d = '0;
        endcase
    end

    // Stage 1: capture shape and amplitude only for a fresh step, so mid-stream changes wait for the next step.
    always_ff @(posedge ref_clock or negedge rst_n) begin
        if (!rst_n) begin
            st1_raw_q  <= '0;
            st1_amp_q  <= '0;
            st1_vld_q  <= 1'b0;
            st1_wrap_q <= 1'b0;
        end else begin
            st1_vld_q  <= upd_q;
            st1_wrap_q <= upd_q & wrap_q;
            if (upd_q) begin
                st1_raw_q <= raw_d;
                st1_amp_q <= amplitude;
            end
        end
    end

    // Scale by (amplitude + 1) so all-ones passes raw through and zero mutes.
    assign amp_p1   = {1'b0, st1_amp_q} + (DATA_W + 1)'(1);
    assign prod     = PROD_W'(st1_raw_q) * PROD_W'(amp_p1);
    assign sample_d = DATA_W'(prod >> DATA_W);

    // Stage 2: the sample only changes together with its valid pulse.
    always_ff @(posedge ref_clock or negedge rst_n) begin
        if (!rst_n) begin
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            period_done_q  <= 1'b0;
        end else begin
            sample_valid_q <= st1_vld_q;
            period_done_q  <= st1_vld_q & st1_wrap_q;
            if (st1_vld_q) begin
                sample_q <= sample_d;
            end
        end
    end

    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign period_done  = period_done_q;

endmodule

// File: tb/tb_wave_gen.sv
`timescale 1ns/1ps
module tb_wave_gen;

    localparam int DW  = 8;
    localparam int PW  = 8;
    localparam int NPH = 1 << PW;

    logic          ref_clock = 1'b0;
    logic          rst_n     = 1'b0;
    logic          enable    = 1'b0;
    logic          phase_clr = 1'b0;
    logic [1:0]    wave_sel  = 2'b00;
    logic [DW-1:0] amplitude = '0;
    logic [PW-1:0] duty_v    = '0;
    logic [DW-1:0] sample;
    logic          sample_valid;
    logic          period_done;
    logic          wave_clock;

    logic gen_lvl = 1'b0;
    logic man_lvl = 1'b0;
    bit   wave_run = 1'b0;
    int   gen_hi = 1, gen_lo = 1, gcnt = 0;
    int   rise_cnt = 0, first_cap = -1, cyc = 0;
    int   total = 0, bad = 0;
    int   mph = 0;
    int   obs_s[$];
    int   obs_pd[$];
    int   obs_c[$];

    assign wave_clock = wave_run ? gen_lvl : man_lvl;

    wave_gen #(.DATA_W(DW), .PHASE_W(PW)) dut (
        .ref_clock    (ref_clock),
        .rst_n        (rst_n),
        .wave_clock   (wave_clock),
        .enable       (enable),
        .phase_clr    (phase_clr),
        .wave_sel     (wave_sel),
        .amplitude    (amplitude),
`ifdef WAVE_GEN_DUTY_CTRL_EN
        .duty         (duty_v),
`endif
        .sample       (sample),
        .sample_valid (sample_valid),
        .period_done  (period_done)
    );

    initial forever #5 ref_clock = ~ref_clock;

    initial forever begin
        @(posedge ref_clock);
        cyc++;
    end

    // Divided-clock generator: gen_lo cycles low, gen_hi cycles high.
    initial forever begin
        @(negedge ref_clock);
        if (!wave_run) begin
            gcnt    = 0;
            gen_lvl = 1'b0;
        end else begin
            gcnt++;
            if (!gen_lvl && gcnt >= gen_lo) begin
                gen_lvl = 1'b1;
                gcnt    = 0;
                rise_cnt++;
                if (first_cap < 0) first_cap = cyc + 1;
            end else if (gen_lvl && gcnt >= gen_hi) begin
                gen_lvl = 1'b0;
                gcnt    = 0;
            end
        end
    end

    // Output monitor.
    initial forever begin
        @(negedge ref_clock);
        if (rst_n && sample_valid) begin
            obs_s.push_back(int'(sample));
            obs_pd.push_back(int'(period_done));
            obs_c.push_back(cyc);
        end
    end

    // Reference: sample value from waveform rules at a given phase.
    function automatic int model_sample(int sel, int amp, int dty, int ph);
        int raw;
        int t;
        raw = 0;
        case (sel)
`ifdef WAVE_GEN_DUTY_CTRL_EN
            0: raw = (ph < dty) ? (1 << DW) - 1 : 0;
`else
            0: raw = (ph < NPH / 2) ? (1 << DW) - 1 : 0;
`endif
            1: raw = (ph * (1 << DW)) / NPH;
            2: begin
                t   = (ph < NPH / 2) ? ph : (NPH - 1 - ph);
                raw = (t * (1 << DW)) / (NPH / 2);
            end
            default: raw = 0;
        endcase
        if (sel == 0 && dty < 0) raw = 0;
        return (raw * (amp + 1)) / (1 << DW);
    endfunction

    task automatic tick();
        @(negedge ref_clock);
        #1;
    endtask

    task automatic run_rises(input int n);
        int r0;
        int b;
        r0 = rise_cnt;
        b  = 0;
        wave_run = 1'b1;
        while ((rise_cnt - r0) < n && b < n * 20 + 100) begin
            tick();
            b++;
        end
        while (gen_lvl) tick();
        wave_run = 1'b0;
        repeat (10) tick();
    endtask

    task automatic manual_pulse(input logic clr);
        man_lvl = 1'b1;
        tick();
        tick();
        phase_clr = clr;
        tick();
        phase_clr = 1'b0;
        man_lvl   = 1'b0;
        repeat (3) tick();
    endtask

    task automatic flush_obs();
        obs_s.delete();
        obs_pd.delete();
        obs_c.delete();
    endtask

    task automatic test_reset();
        #2;
        total++; if (sample !== '0)      begin bad++; $display("FAIL reset_sample got=%0h exp=0", sample); end
        total++; if (sample_valid !== 0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", sample_valid); end
        total++; if (period_done !== 0)  begin bad++; $display("FAIL reset_pdone got=%0b exp=0", period_done); end
        repeat (3) tick();
        total++; if (sample !== '0)      begin bad++; $display("FAIL reset_hold_sample got=%0h exp=0", sample); end
        total++; if (sample_valid !== 0) begin bad++; $display("FAIL reset_hold_valid got=%0b exp=0", sample_valid); end
        rst_n = 1'b1;
        repeat (3) tick();
        total++; if (sample_valid !== 0) begin bad++; $display("FAIL idle_valid got=%0b exp=0", sample_valid); end
    endtask

    task automatic test_sawtooth();
        int n;
        int lat;
        int e;
        wave_sel  = 2'd1;
        amplitude = 8'd255;
        enable    = 1'b1;
        gen_hi = 1; gen_lo = 1;
        first_cap = -1;
        run_rises(300);
        n   = obs_s.size();
        lat = (n > 0) ? obs_c[0] - first_cap : -1;
        total++; if (lat != 4) begin bad++; $display("FAIL saw_latency got=%0d exp=4", lat); end
        total++; if (n != 300) begin bad++; $display("FAIL saw_count got=%0d exp=300", n); end
        for (int i = 1; i < n; i++) begin
            total++;
            if (obs_c[i] - obs_c[i-1] != 2) begin
                bad++; $display("FAIL saw_interval idx=%0d got=%0d exp=2", i, obs_c[i] - obs_c[i-1]);
            end
        end
        for (int i = 0; i < n; i++) begin
            mph = (mph + 1) % NPH;
            e   = model_sample(1, 255, 0, mph);
            total++; if (obs_s[i] != e) begin bad++; $display("FAIL saw_sample ph=%0d got=%0d exp=%0d", mph, obs_s[i], e); end
            total++; if (obs_pd[i] != ((mph == 0) ? 1 : 0)) begin
                bad++; $display("FAIL saw_pdone ph=%0d got=%0d exp=%0d", mph, obs_pd[i], (mph == 0) ? 1 : 0);
            end
        end
        flush_obs();
    endtask

    task automatic test_triangle();
        int n;
        int e;
        int ec;
        wave_sel  = 2'd2;
        amplitude = 8'd255;
        run_rises(NPH);
        n = obs_s.size();
        total++; if (n != NPH) begin bad++; $display("FAIL tri_count got=%0d exp=%0d", n, NPH); end
        for (int i = 0; i < n; i++) begin
            mph = (mph + 1) % NPH;
            e   = model_sample(2, 255, 0, mph);
            total++; if (obs_s[i] != e) begin bad++; $display("FAIL tri_sample ph=%0d got=%0d exp=%0d", mph, obs_s[i], e); end
            ec = (mph == 127 || mph == 128) ? 254 : (mph == 255) ? 0 : (mph == 1) ? 2 : -1;
            if (ec >= 0) begin
                total++; if (obs_s[i] != ec) begin bad++; $display("FAIL tri_point ph=%0d got=%0d exp=%0d", mph, obs_s[i], ec); end
            end
        end
        flush_obs();
    endtask

    task automatic test_square();
        int n;
        int lim;
        int e;
        wave_sel  = 2'd0;
        amplitude = 8'd128;
        duty_v    = 8'd64;
`ifdef WAVE_GEN_DUTY_CTRL_EN
        lim = 64;
`else
        lim = 128;
`endif
        run_rises(NPH);
        n = obs_s.size();
        total++; if (n != NPH) begin bad++; $display("FAIL sq_count got=%0d exp=%0d", n, NPH); end
        for (int i = 0; i < n; i++) begin
            mph = (mph + 1) % NPH;
            e   = (mph < lim) ? 128 : 0;
            total++; if (obs_s[i] != e) begin bad++; $display("FAIL sq_sample ph=%0d got=%0d exp=%0d", mph, obs_s[i], e); end
        end
        flush_obs();
    endtask

    task automatic test_enable_hold();
        int r0;
        int b;
        int n;
        int n_before;
        int e;
        logic [DW-1:0] held;
        wave_sel  = 2'd1;
        amplitude = DW'($urandom_range(100, 255));
        gen_hi = 1; gen_lo = 2;
        r0 = rise_cnt;
        b  = 0;
        wave_run = 1'b1;
        while ((rise_cnt - r0) < 15 && b < 500) begin tick(); b++; end
        enable = 1'b0;
        repeat (6) tick();
        held     = sample;
        n_before = obs_s.size();
        for (int i = 0; i < 30; i++) begin
            tick();
            total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL hold_valid cyc=%0d got=%0b exp=0", i, sample_valid); end
            total++; if (sample !== held) begin bad++; $display("FAIL hold_sample cyc=%0d got=%0d exp=%0d", i, sample, held); end
        end
        enable = 1'b1;
        r0 = rise_cnt;
        b  = 0;
        while ((rise_cnt - r0) < 20 && b < 500) begin tick(); b++; end
        while (gen_lvl) tick();
        wave_run = 1'b0;
        repeat (10) tick();
        n = obs_s.size();
        total++; if (n - n_before < 19) begin bad++; $display("FAIL hold_resume_count got=%0d exp>=19", n - n_before); end
        for (int i = 0; i < n; i++) begin
            mph = (mph + 1) % NPH;
            e   = model_sample(1, int'(amplitude), 0, mph);
            total++; if (obs_s[i] != e) begin bad++; $display("FAIL hold_seq idx=%0d ph=%0d got=%0d exp=%0d", i, mph, obs_s[i], e); end
        end
        flush_obs();
    endtask

    task automatic test_phase_clr();
        int n;
        wave_sel  = 2'd1;
        amplitude = 8'd255;
        tick();
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        repeat (6) tick();
        total++; if (obs_s.size() != 0) begin bad++; $display("FAIL clr_alone_valid got=%0d exp=0", obs_s.size()); end
        mph = 0;
        for (int i = 0; i < 200; i++) manual_pulse(1'b0);
        n = obs_s.size();
        total++; if (n != 200) begin bad++; $display("FAIL clr_pre_count got=%0d exp=200", n); end
        for (int i = 0; i < n; i++) begin
            mph = (mph + 1) % NPH;
            total++; if (obs_s[i] != mph) begin bad++; $display("FAIL clr_pre_sample got=%0d exp=%0d", obs_s[i], mph); end
        end
        flush_obs();
        manual_pulse(1'b1);
        repeat (6) tick();
        total++; if (obs_s.size() != 0) begin bad++; $display("FAIL clr_step_valid got=%0d exp=0", obs_s.size()); end
        mph = 0;
        manual_pulse(1'b0);
        repeat (6) tick();
        n = obs_s.size();
        total++; if (n != 1) begin bad++; $display("FAIL clr_next_count got=%0d exp=1", n); end
        if (n > 0) begin
            total++; if (obs_s[0] != 1)  begin bad++; $display("FAIL clr_next_sample got=%0d exp=1", obs_s[0]); end
            total++; if (obs_pd[0] != 0) begin bad++; $display("FAIL clr_next_pdone got=%0d exp=0", obs_pd[0]); end
        end
        mph = 1;
        flush_obs();
    endtask

    task automatic test_random();
        int n;
        int cnt;
        int e;
        int sel;
        int amp;
        for (int seg = 0; seg < 8; seg++) begin
            sel = (seg < 4) ? seg : int'($urandom_range(0, 3));
            amp = (seg == 0) ? 0 : (seg == 1) ? 255 : int'($urandom_range(0, 255));
            wave_sel  = 2'(sel);
            amplitude = DW'(amp);
            duty_v    = PW'($urandom);
            gen_hi    = int'($urandom_range(1, 3));
            gen_lo    = int'($urandom_range(1, 3));
            n         = int'($urandom_range(20, 80));
            run_rises(n);
            cnt = obs_s.size();
            total++; if (cnt != n) begin bad++; $display("FAIL rnd_count seg=%0d got=%0d exp=%0d", seg, cnt, n); end
            for (int i = 0; i < cnt; i++) begin
                mph = (mph + 1) % NPH;
                e   = model_sample(sel, amp, int'(duty_v), mph);
                total++; if (obs_s[i] != e) begin
                    bad++; $display("FAIL rnd_sample seg=%0d sel=%0d amp=%0d ph=%0d got=%0d exp=%0d", seg, sel, amp, mph, obs_s[i], e);
                end
                total++; if (obs_pd[i] != ((mph == 0) ? 1 : 0)) begin
                    bad++; $display("FAIL rnd_pdone seg=%0d ph=%0d got=%0d", seg, mph, obs_pd[i]);
                end
            end
            flush_obs();
        end
    endtask

    task automatic test_async_reset();
        int r0;
        int b;
        int n;
        int lat;
        wave_sel  = 2'd1;
        amplitude = 8'd255;
        gen_hi = 1; gen_lo = 1;
        r0 = rise_cnt;
        b  = 0;
        wave_run = 1'b1;
        while ((rise_cnt - r0) < 40 && b < 500) begin tick(); b++; end
        @(posedge ref_clock);
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (sample !== '0)      begin bad++; $display("FAIL areset_sample got=%0h exp=0", sample); end
        total++; if (sample_valid !== 0) begin bad++; $display("FAIL areset_valid got=%0b exp=0", sample_valid); end
        total++; if (period_done !== 0)  begin bad++; $display("FAIL areset_pdone got=%0b exp=0", period_done); end
        while (gen_lvl) tick();
        wave_run = 1'b0;
        repeat (3) tick();
        flush_obs();
        rst_n = 1'b1;
        repeat (3) tick();
        mph = 0;
        first_cap = -1;
        run_rises(30);
        n   = obs_s.size();
        lat = (n > 0) ? obs_c[0] - first_cap : -1;
        total++; if (lat != 4) begin bad++; $display("FAIL areset_latency got=%0d exp=4", lat); end
        total++; if (n != 30) begin bad++; $display("FAIL areset_count got=%0d exp=30", n); end
        for (int i = 0; i < n; i++) begin
            mph = (mph + 1) % NPH;
            total++; if (obs_s[i] != mph) begin bad++; $display("FAIL areset_sample_seq got=%0d exp=%0d", obs_s[i], mph); end
        end
        flush_obs();
    endtask

    initial begin
        test_reset();
        test_sawtooth();
        test_triangle();
        test_square();
        test_enable_hold();
        test_phase_clr();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_gen.md
Name: wave_gen

Overview:
- Downstream consumer of the clock divider's out_clock.
- Runs entirely in the ref_clock domain. It synchronises the divided clock and detects each of its rising edges.
- Each detected edge advances a phase counter by one step.
- From the phase it produces square, sawtooth or triangle samples, scaled by a programmable amplitude, with a valid strobe for the DAC/sample sink.

Parameters:
- DATA_W, 8: sample and amplitude width in bits.
- PHASE_W, 8: phase counter width; one waveform period is 2^PHASE_W steps. Must be >= 2.

Ports:
- ref_clock  in  1  system clock; the same clock that drives the divider.
- rst_n  in  1  asynchronous, active-low reset.
- wave_clock  in  1  divided clock from the divider; treated as a data signal and synchronised internally.
- enable  in  1  high = steps are counted; low = phase and output are frozen.
- phase_clr  in  1  synchronous single-cycle request to restart the period.
- wave_sel  in  2  waveform select: 00 square, 01 sawtooth, 10 triangle, 11 zero.
- amplitude  in  DATA_W  amplitude scale; all-ones = full scale.
- sample  out  DATA_W  current output sample.
- sample_valid  out  1  one-cycle pulse, aligned with each new sample.
- period_done  out  1  one-cycle pulse, aligned with the sample_valid of the sample at which the phase wrapped to 0.

Behaviour:
- Reset (asynchronous, takes effect immediately with no clock edge): the following all clear to 0.
  - sync flops, phase, pipeline registers
  - sample, sample_valid, period_done
- Synchroniser: three flops s1 -> s2 -> s3. step = s2 & ~s3 & enable (combinational).
- Supported divisor range: divisor >= 2, i.e. wave_clock high and low each for at least 1 ref_clock cycle.
  - divisor = 1 (wave_clock equal to ref_clock) is unsupported: the step rate is undefined, but the block must not lock up.
- Phase stage (PHASE_W bits), evaluated at each ref_clock edge:
  - phase_clr = 1: phase <= 0. Takes priority over step. No wrap flag is set.
  - otherwise, step = 1: phase <= phase + 1, wrapping from max to 0. The wrap flag is set when the new phase is 0.
  - otherwise: phase holds.
- Stage 1 (registered on the cycle after a phase update by step):
  - Capture wave_sel and amplitude.
  - Compute raw (DATA_W bits) from phase:
    - Square: all-ones when phase < 2^(PHASE_W-1), otherwise 0.
    - Sawtooth: phase resized to DATA_W. Take the top DATA_W bits if PHASE_W >= DATA_W; otherwise left-justify and zero-fill.
    - Triangle: lower PHASE_W-1 bits of phase when the phase MSB = 0, bitwise-inverted when MSB = 1. Resized to DATA_W as for sawtooth, from PHASE_W-1 bits.
    - Zero: 0.
- Stage 2 (registered on the next cycle):
  - sample <= (raw * (amplitude + 1)) >> DATA_W. The product uses a 2*DATA_W+1-bit intermediate and truncates.
  - amplitude = all-ones gives raw exactly; amplitude = 0 gives 0.
  - sample_valid = 1 for exactly this one cycle.
  - period_done = 1 in the same cycle if the wrap flag was carried with this step.
- Latency: sample_valid is asserted 4 ref_clock edges after the first edge at which s1 captures wave_clock high.
  - Steps are pipelined, so back-to-back steps at divisor = 2 give one sample_valid every 2 cycles.
- enable low:
  - No steps; phase holds.
  - No sample_valid or period_done; sample keeps its last value.
  - Samples already in the pipeline still complete.
- wave_sel and amplitude changes take effect on the next step only. No glitch is allowed on sample between valid pulses.
- A phase_clr arriving in the same cycle as step wins. That step is lost, and no sample_valid is generated for it.

Optional Feature:
- Macro: WAVE_GEN_DUTY_CTRL_EN
- Defined:
  - Adds input port duty, width PHASE_W, captured at stage 1 together with wave_sel.
  - Square raw = all-ones when phase < duty, otherwise 0.
  - duty = 0 gives a constant 0.
- Undefined:
  - Port is absent.
  - Square is fixed at 50% duty (phase MSB = 0 gives high).

Test Plan:
- Reset release; wave_clock from a divide-by-2; sawtooth, amplitude 255, enable 1 -> samples 1, 2, ..., 255, 0, 1, ... with sample_valid every 2 cycles. period_done is set only on the sample value 0 following 255.
- Triangle, amplitude 255, PHASE_W = DATA_W = 8 -> phase 127 gives 254; phase 128 gives 254; phase 255 gives 0; phase 1 gives 2.
- Square, amplitude 128 -> phases 0..127 give sample 128; phases 128..255 give 0. With WAVE_GEN_DUTY_CTRL_EN and duty 64: high only for phases 0..63.
- Drop enable for 10 wave_clock periods mid-stream -> no sample_valid and sample constant; after enable returns, the next sample continues from the held phase + 1.
- Assert phase_clr in the same cycle as a step at phase 200 -> phase becomes 0, no period_done; next step yields the phase-1 sample.
- Drop rst_n asynchronously between clock edges mid-stream -> sample, sample_valid and period_done are 0 before the next ref_clock edge. After release, the first sample_valid occurs 4 edges after wave_clock is first sampled high.
